key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner_pkg.sv | 29 ++
 rtl/key_conditioner_if.sv | 18 +
 rtl/key_conditioner_debounce.sv | 94 +++++++++
 rtl/key_conditioner.sv | 41 ++++
 tb/tb_key_conditioner.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/key_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// key_conditioner_pkg : debounce state encoding, defaults, key index map
// Revision: 1.0
// ============================================================================
package key_conditioner_pkg;

   localparam int c_DEBOUNCE_CYCLES = 500000;
   localparam int c_CNT_W           = 20;
   localparam int c_NUM_KEYS        = 3;

   localparam int c_KEY_RIGHT = 0;
   localparam int c_KEY_FIRE  = 1;
   localparam int c_KEY_LEFT  = 2;

   typedef enum logic [1:0] {
      DB_IDLE         = 2'd0,
      DB_PRESS_WAIT   = 2'd1,
      DB_PRESSED      = 2'd2,
      DB_RELEASE_WAIT = 2'd3
   } db_state_t;

   // Opposing directions cancel rather than favouring one side.
   function automatic logic [1:0] move_map(input logic left, input logic right);
      return (left & right) ? 2'b00 : {left, right};
   endfunction

endpackage
`default_nettype wire

// File: rtl/key_conditioner_if.sv
`default_nettype none
// ============================================================================
// key_conditioner_if : raw key inputs and conditioned game-control outputs
// Revision: 1.0
// ============================================================================
interface key_conditioner_if;
   import key_conditioner_pkg::*;

   logic [c_NUM_KEYS-1:0] key_n;
   logic [1:0]            move;
   logic                  fire_held;
   logic                  fire_pulse;
   logic [c_NUM_KEYS-1:0] key_level;

   modport master (output key_n, input move, fire_held, fire_pulse, key_level);
   modport slave  (input key_n, output move, fire_held, fire_pulse, key_level);
endinterface
`default_nettype wire

// File: rtl/key_conditioner_debounce.sv
`default_nettype none
// ============================================================================
// key_debounce : 2-flop synchronizer, 4-state debounce FSM, saturating counter
// Revision: 1.0
// ============================================================================
module key_debounce
   import key_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES,
   parameter int CNT_W           = c_CNT_W
) (
   input  wire logic clk,
   input  wire logic resetn,
   input  wire logic i_key_n,
   output logic      o_level,
   output logic      o_press
);

   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

   logic [1:0]       r_sync;
   db_state_t        r_state;
   db_state_t        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_raw_pressed;
   logic             w_level_nxt;
   logic             r_level;
   logic             r_press;

   assign w_raw_pressed = ~r_sync[1];
   assign w_level_nxt   = (r_state == DB_PRESSED) || (r_state == DB_RELEASE_WAIT);
   assign w_cnt_inc     = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

   // Synchronizer resets to the released level so reset never looks like a press.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_sync  <= 2'b11;
         r_state <= DB_IDLE;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_press <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_key_n};
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
         r_press <= w_level_nxt & ~r_level;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         DB_IDLE: begin
            if (w_raw_pressed) begin
               w_state_nxt = DB_PRESS_WAIT;
               w_cnt_nxt   = CNT_W'(1);
            end
         end
         DB_PRESS_WAIT: begin
            if (!w_raw_pressed)
               w_state_nxt = DB_IDLE;
            else if (r_cnt >= c_CNT_LAST)
               w_state_nxt = DB_PRESSED;
            else
               w_cnt_nxt = w_cnt_inc;
         end
         DB_PRESSED: begin
            if (!w_raw_pressed) begin
               w_state_nxt = DB_RELEASE_WAIT;
               w_cnt_nxt   = CNT_W'(1);
            end
         end
         DB_RELEASE_WAIT: begin
            if (w_raw_pressed)
               w_state_nxt = DB_PRESSED;
            else if (r_cnt >= c_CNT_LAST)
               w_state_nxt = DB_IDLE;
            else
               w_cnt_nxt = w_cnt_inc;
         end
         default: w_state_nxt = DB_IDLE;
      endcase
   end

   assign o_level = r_level;
   assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// key_conditioner : three debounced keys mapped to move / fire controls
// Revision: 1.0
// ============================================================================
module key_conditioner
   import key_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES,
   parameter int CNT_W           = c_CNT_W
) (
   input  wire logic         clk,
   input  wire logic         resetn,
   key_conditioner_if.slave  bus
);

   localparam logic [c_NUM_KEYS-1:0] c_FIRE_MASK = c_NUM_KEYS'(1) << c_KEY_FIRE;

   logic [c_NUM_KEYS-1:0] w_level;
   logic [c_NUM_KEYS-1:0] w_press;

   for (genvar gi = 0; gi < c_NUM_KEYS; gi++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_key_debounce (
         .clk     (clk),
         .resetn  (resetn),
         .i_key_n (bus.key_n[gi]),
         .o_level (w_level[gi]),
         .o_press (w_press[gi])
      );
   end

   assign bus.key_level  = w_level;
   assign bus.fire_held  = w_level[c_KEY_FIRE];
   assign bus.fire_pulse = |(w_press & c_FIRE_MASK);
   assign bus.move       = move_map(w_level[c_KEY_LEFT], w_level[c_KEY_RIGHT]);

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
// tb_key_conditioner : scoreboard bench, expected output changes queued by cycle
// Revision: 1.0
// ============================================================================
module tb_key_conditioner;
   import key_conditioner_pkg::*;

   localparam int DB  = 4;
   localparam int LAT = DB + 3;   // drive-before-edge-n -> visible at negedge n+LAT

   typedef struct packed {
      logic [31:0] cyc;
      logic [6:0]  out;   // {key_level, move, fire_held, fire_pulse}
   } ev_t;

   logic clk = 1'b0;
   logic resetn;
   int   ecnt = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   bit   mon_en = 1'b0;
   logic [6:0] prev_snap;
   ev_t  exp_q[$];

   key_conditioner_if bus();

   key_conditioner #(
      .DEBOUNCE_CYCLES (DB),
      .CNT_W           (4)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #10 clk = ~clk;
   always @(posedge clk) ecnt <= ecnt + 1;

   function automatic logic [6:0] snap();
      return {bus.key_level, bus.move, bus.fire_held, bus.fire_pulse};
   endfunction

   task automatic chk(input bit ok, input string name, input logic [31:0] got, input logic [31:0] req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, got, req);
   endtask

   task automatic push(input int cyc, input logic [2:0] lvl, input logic [1:0] mv,
                       input logic held, input logic pulse);
      ev_t e;
      e.cyc = cyc;
      e.out = {lvl, mv, held, pulse};
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic [2:0] k, output int n);
      @(negedge clk);
      bus.key_n = k;
      n = ecnt;
   endtask

   task automatic idle(input int c);
      repeat (c) @(negedge clk);
   endtask

   // Monitor: every change of the output bundle must match the next queued event.
   initial begin
      logic [6:0] s;
      ev_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            s = snap();
            if (s !== prev_snap) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  $display("FAIL unexpected_change: cyc %0d out %b, required no change from %b",
                           ecnt, s, prev_snap);
               end else begin
                  e = exp_q.pop_front();
                  if (s === e.out && ecnt == int'(e.cyc))
                     n_pass++;
                  else
                     $display("FAIL event: cyc %0d out %b, required cyc %0d out %b",
                              ecnt, s, e.cyc, e.out);
               end
               prev_snap = s;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time %0t, required completion earlier", $time);
      $fatal(1);
   end

   initial begin
      int n;
      resetn    = 1'b0;
      bus.key_n = 3'b111;
      prev_snap = '0;
      idle(3);
      chk(bus.key_level === 3'b000, "rst_key_level", 32'(bus.key_level), 0);
      chk(bus.move === 2'b00,       "rst_move",      32'(bus.move), 0);
      chk(bus.fire_held === 1'b0,   "rst_fire_held", 32'(bus.fire_held), 0);
      chk(bus.fire_pulse === 1'b0,  "rst_fire_pulse", 32'(bus.fire_pulse), 0);
      resetn = 1'b1;
      mon_en = 1'b1;
      idle(3);

      // Clean KEY2 press and release
      drive(3'b101, n);
      push(n + LAT,     3'b010, 2'b00, 1'b1, 1'b1);
      push(n + LAT + 1, 3'b010, 2'b00, 1'b1, 1'b0);
      idle(20);
      drive(3'b111, n);
      push(n + LAT, 3'b000, 2'b00, 1'b0, 1'b0);
      idle(12);

      // Glitch one cycle too short to be accepted
      drive(3'b101, n);
      idle(2);
      drive(3'b111, n);
      idle(12);
      chk(bus.key_level === 3'b000, "glitch_key_level", 32'(bus.key_level), 0);

      // Bounce on release: high 2, low 1, then high
      drive(3'b101, n);
      push(n + LAT,     3'b010, 2'b00, 1'b1, 1'b1);
      push(n + LAT + 1, 3'b010, 2'b00, 1'b1, 1'b0);
      idle(15);
      drive(3'b111, n);
      idle(1);
      drive(3'b101, n);
      drive(3'b111, n);
      push(n + LAT, 3'b000, 2'b00, 1'b0, 1'b0);
      idle(15);

      // Move conflict mapping
      drive(3'b110, n);
      push(n + LAT, 3'b001, 2'b01, 1'b0, 1'b0);
      idle(12);
      drive(3'b010, n);
      push(n + LAT, 3'b101, 2'b00, 1'b0, 1'b0);
      idle(12);
      drive(3'b011, n);
      push(n + LAT, 3'b100, 2'b10, 1'b0, 1'b0);
      idle(12);
      drive(3'b111, n);
      push(n + LAT, 3'b000, 2'b00, 1'b0, 1'b0);
      idle(12);

      // All keys together, independent debouncers land on the same cycle
      drive(3'b000, n);
      push(n + LAT,     3'b111, 2'b00, 1'b1, 1'b1);
      push(n + LAT + 1, 3'b111, 2'b00, 1'b1, 1'b0);
      idle(15);
      drive(3'b111, n);
      push(n + LAT, 3'b000, 2'b00, 1'b0, 1'b0);
      idle(12);

      // Reset during PRESS_WAIT of KEY2 with the key still held
      drive(3'b101, n);
      idle(4);
      resetn = 1'b0;
      idle(1);
      chk(snap() === 7'b0, "reset_mid_outputs_a", 32'(snap()), 0);
      idle(1);
      chk(snap() === 7'b0, "reset_mid_outputs_b", 32'(snap()), 0);
      idle(1);
      resetn = 1'b1;
      n = ecnt;
      push(n + LAT,     3'b010, 2'b00, 1'b1, 1'b1);
      push(n + LAT + 1, 3'b010, 2'b00, 1'b1, 1'b0);
      idle(15);
      drive(3'b111, n);
      push(n + LAT, 3'b000, 2'b00, 1'b0, 1'b0);
      idle(15);

      chk(exp_q.size() == 0, "exp_queue_drained", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
